// File: rtl/keystream_sequencer.sv
// keystream_sequencer
//  Sequences the ksg keystream datapath to encrypt a plaintext bit stream of
//  programmable length. On an accepted start it latches key, nonce, initial
//  block counter and message length. It then drives the ksg counter block by
//  block, captures each KS_W-bit keystream word and serialises it MSB-first,
//  XORed with plaintext, under valid/ready handshakes.
//
// Ports
//  clk, reset            clock, synchronous active-high reset
//  start                 begin message (sampled only while idle)
//  key/nonce/init_ctr    per-message parameters, latched on accepted start
//  msg_len               message length in bits, latched on accepted start
//  ksg_key/ksg_nonce     latched key/nonce to ksg
//  ksg_counter           current block counter to ksg
//  ksg_data              keystream word from ksg (valid KS_LAT cycles after counter change)
//  pt_valid/pt_bit/pt_ready   plaintext bit stream in
//  ct_valid/ct_bit/ct_ready   ciphertext bit stream out
//  busy                  high whenever not idle
//  done                  one-cycle pulse at message end
//  err                   sticky counter-exhausted flag, cleared by next accepted start
//
// Configuration
//  KSC_STATUS_EN         adds blocks_used: number of keystream words captured
//                        for the current/last message.

module keystream_sequencer #(
  parameter int unsigned CTR_W  = 2,
  parameter int unsigned KS_W   = 16,
  parameter int unsigned KS_LAT = 1,
  parameter int unsigned LEN_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       key,
  input  logic [1:0]       nonce,
  input  logic [CTR_W-1:0] init_ctr,
  input  logic [LEN_W-1:0] msg_len,
  output logic [7:0]       ksg_key,
  output logic [1:0]       ksg_nonce,
  output logic [CTR_W-1:0] ksg_counter,
  input  logic [KS_W-1:0]  ksg_data,
  input  logic             pt_valid,
  input  logic             pt_bit,
  output logic             pt_ready,
  output logic             ct_valid,
  output logic             ct_bit,
  input  logic             ct_ready,
  output logic             busy,
  output logic             done,
`ifdef KSC_STATUS_EN
  output logic [CTR_W:0]   blocks_used,
`endif
  output logic             err
);

  localparam int unsigned IdxW  = (KS_W > 1) ? $clog2(KS_W) : 1;
  localparam int unsigned WaitW = (KS_LAT > 1) ? $clog2(KS_LAT) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StGen, StStream, StFin} state_e;

  state_e            state_q;
  logic [CTR_W-1:0]  init_ctr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [KS_W-1:0]   shreg_q;
  logic [IdxW-1:0]   idx_q;
  logic [WaitW-1:0]  wait_q;
  logic [CTR_W-1:0]  next_ctr;
  logic              xfer;

  assign next_ctr = ksg_counter + CTR_W'(1);
  assign xfer     = (state_q == StStream) && pt_valid && ct_ready;

  // Stream-side handshake is combinational so a bit can move every cycle.
  always_comb begin
    ct_valid = 1'b0;
    pt_ready = 1'b0;
    ct_bit   = 1'b0;
    if (state_q == StStream) begin
      ct_valid = pt_valid;
      pt_ready = ct_ready;
      ct_bit   = shreg_q[idx_q] ^ pt_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ksg_key     <= '0;
      ksg_nonce   <= '0;
      ksg_counter <= '0;
      init_ctr_q  <= '0;
      remaining_q <= '0;
      shreg_q     <= '0;
      idx_q       <= '0;
      wait_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
`ifdef KSC_STATUS_EN
      blocks_used <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            ksg_key     <= key;
            ksg_nonce   <= nonce;
            init_ctr_q  <= init_ctr;
            remaining_q <= msg_len;
            err         <= 1'b0;
            busy        <= 1'b1;
            state_q     <= StLoad;
`ifdef KSC_STATUS_EN
            blocks_used <= '0;
`endif
          end
        end
        StLoad: begin
          ksg_counter <= init_ctr_q;
          wait_q      <= '0;
          if (remaining_q == '0) begin
            done    <= 1'b1;
            state_q <= StFin;
          end else begin
            state_q <= StGen;
          end
        end
        StGen: begin
          // Counter has been stable for KS_LAT cycles on the last wait cycle.
          if (wait_q == WaitW'(KS_LAT - 1)) begin
            shreg_q <= ksg_data;
            idx_q   <= IdxW'(KS_W - 1);
            state_q <= StStream;
`ifdef KSC_STATUS_EN
            blocks_used <= blocks_used + (CTR_W + 1)'(1);
`endif
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StStream: begin
          if (xfer) begin
            remaining_q <= remaining_q - LEN_W'(1);
            idx_q       <= idx_q - IdxW'(1);
            if (remaining_q == LEN_W'(1)) begin
              done    <= 1'b1;
              state_q <= StFin;
            end else if (idx_q == '0) begin
              // Wrapping back to the first block would reuse keystream.
              if (next_ctr == init_ctr_q) begin
                err     <= 1'b1;
                done    <= 1'b1;
                state_q <= StFin;
              end else begin
                ksg_counter <= next_ctr;
                wait_q      <= '0;
                state_q     <= StGen;
              end
            end
          end
        end
        StFin: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_keystream_sequencer.sv
module tb_keystream_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  key;
  logic [1:0]  nonce;
  logic [1:0]  init_ctr;
  logic [7:0]  msg_len;
  logic [7:0]  ksg_key;
  logic [1:0]  ksg_nonce;
  logic [1:0]  ksg_counter;
  logic [15:0] ksg_data;
  logic        pt_valid, pt_bit, pt_ready;
  logic        ct_valid, ct_bit, ct_ready;
  logic        busy, done, err;

  keystream_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .nonce(nonce),
    .init_ctr(init_ctr), .msg_len(msg_len), .ksg_key(ksg_key), .ksg_nonce(ksg_nonce),
    .ksg_counter(ksg_counter), .ksg_data(ksg_data), .pt_valid(pt_valid), .pt_bit(pt_bit),
    .pt_ready(pt_ready), .ct_valid(ct_valid), .ct_bit(ct_bit), .ct_ready(ct_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // ksg model with KS_LAT=1: word is a function of the counter driven one cycle earlier.
  function automatic logic [15:0] ks_fn(input logic [1:0] c);
    case (c)
      2'd0: ks_fn = 16'h0000;
      2'd1: ks_fn = 16'hA5C3;
      2'd2: ks_fn = 16'h3C96;
      default: ks_fn = 16'hFFFF;
    endcase
  endfunction
  assign ksg_data = ks_fn(ksg_counter);

  int n_pass = 0, n_total = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: expected ciphertext stream for the current message.
  logic       pt_arr [128];
  logic       exp_bit[128];
  logic [1:0] exp_ctr[128];
  int         exp_n;
  logic       exp_err;
  int         tx_k, done_cnt, first_cyc, done_cyc, start_cyc;
  logic [63:0] ct_word;
  logic       prev_stall, prev_bit;
  logic [7:0] cur_key;

  task automatic build_model(input logic [1:0] ic, input int len, input int ptm);
    logic [15:0] w;
    logic [1:0]  blk;
    exp_n   = (len > 64) ? 64 : len;
    exp_err = (len > 64);
    for (int k = 0; k < 128; k++)
      pt_arr[k] = (ptm == 0) ? 1'b0 : (ptm == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    for (int k = 0; k < exp_n; k++) begin
      blk = 2'((int'(ic) + k / 16) % 4);
      w = ks_fn(blk);
      exp_ctr[k] = blk;
      exp_bit[k] = w[15 - k % 16] ^ pt_arr[k];
    end
    tx_k = 0; done_cnt = 0; first_cyc = -1; done_cyc = -1; ct_word = '0;
    prev_stall = 1'b0;
  endtask

  // Compare process: every transfer against the model, plus hold stability.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_stall && ct_valid) chk("ct_hold", 64'(ct_bit), 64'(prev_bit));
      if (ct_valid && first_cyc < 0) first_cyc = cyc_cnt;
      if (ct_valid && ct_ready) begin
        if (tx_k < exp_n) begin
          chk("ct_bit", 64'(ct_bit), 64'(exp_bit[tx_k]));
          chk("ksg_counter", 64'(ksg_counter), 64'(exp_ctr[tx_k]));
        end else begin
          chk("extra_ct_xfer", 64'(tx_k), 64'(exp_n - 1));
        end
        ct_word = {ct_word[62:0], ct_bit};
        tx_k++;
      end
      prev_stall = ct_valid && !ct_ready;
      prev_bit   = ct_bit;
      if (done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic run_msg(input logic [1:0] ic, input int len, input int ptm,
                         input bit rnd, input bit poke, input int abort_at);
    int cyc;
    build_model(ic, len, ptm);
    cur_key = 8'($urandom_range(0, 254));
    @(posedge clk); #1;
    start = 1'b1; key = cur_key; nonce = 2'($urandom_range(0, 3));
    init_ctr = ic; msg_len = 8'(len);
    start_cyc = cyc_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("err_cleared", 64'(err), 64'd0);
    chk("key_latched", 64'(ksg_key), 64'(cur_key));
    chk("nonce_latched", 64'(ksg_nonce), 64'(nonce));
    key = 8'hFF;
    cyc = 0;
    while (done_cnt == 0 && cyc < 600) begin
      if (abort_at > 0 && tx_k == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_outputs", 64'({ksg_key, ksg_nonce, ksg_counter, pt_ready, ct_valid,
                                  ct_bit, busy, done, err}), 64'd0);
        reset = 1'b0; pt_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_after_reset", 64'(done_cnt), 64'd0);
        return;
      end
      pt_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      ct_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      pt_bit   = pt_arr[tx_k];
      start    = poke && (cyc == 4);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; pt_valid = 1'b0; ct_ready = 1'b1;
    chk("done_seen", 64'(done_cnt != 0), 64'd1);
    chk("busy_low_after_fin", 64'(busy), 64'd0);
    chk("err_flag", 64'(err), 64'(exp_err));
    chk("bit_count", 64'(tx_k), 64'(exp_n));
    chk("key_held", 64'(ksg_key), 64'(cur_key));
    @(negedge clk);
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("done_low_idle", 64'(done), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key = '0; nonce = '0; init_ctr = '0; msg_len = '0;
    pt_valid = 1'b0; pt_bit = 1'b0; ct_ready = 1'b1;
    exp_n = 0; tx_k = 0; done_cnt = 0; prev_stall = 1'b0; prev_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 64'({ksg_key, ksg_nonce, ksg_counter, pt_ready, ct_valid, ct_bit,
                            busy, done, err}), 64'd0);
    reset = 1'b0;

    // 1: single block, pt=0 gives raw keystream MSB-first.
    run_msg(2'd1, 16, 0, 1'b0, 1'b0, 0);
    chk("t1_word", ct_word, 64'h0000_0000_0000_A5C3);
    chk("t1_first_valid_lat", 64'(first_cyc - start_cyc), 64'd3);

    // 2: pt=1 inverts; short message stops early.
    run_msg(2'd1, 16, 1, 1'b0, 1'b0, 0);
    chk("t2_word", ct_word, 64'h0000_0000_0000_5A3C);
    run_msg(2'd1, 5, 1, 1'b0, 1'b0, 0);
    chk("t2_len5", ct_word, 64'h0000_0000_0000_000B);

    // 3: counter wrap 3->0 within the allowed range.
    run_msg(2'd3, 20, 0, 1'b0, 1'b0, 0);
    chk("t3_word", ct_word, 64'h0000_0000_000F_FFF0);

    // 4: exhaust all four blocks, err raised, next start clears it.
    run_msg(2'd2, 65, 0, 1'b0, 1'b0, 0);
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_count", 64'(tx_k), 64'd64);
    run_msg(2'd2, 5, 2, 1'b0, 1'b0, 0);

    // 5: random backpressure/gaps, start while busy ignored, zero-length message.
    run_msg(2'd0, 40, 2, 1'b1, 1'b1, 0);
    run_msg(2'd3, 64, 2, 1'b1, 1'b0, 0);
    run_msg(2'd1, 0, 0, 1'b0, 1'b0, 0);
    chk("t5_len0_done_lat", 64'(done_cyc - start_cyc), 64'd2);
    chk("t5_len0_no_valid", 64'(first_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

    // 6: reset mid-block, then a clean message afterwards.
    run_msg(2'd1, 16, 0, 1'b0, 1'b0, 8);
    run_msg(2'd2, 16, 2, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
